// File: rtl/nibble_divider.sv
// -----------------------------------------------------------------------------
// nibble_divider
//
// Byte-command divider. A command byte is registered into in_q, then decoded
// while the FSM is idle: ops load a 4-bit divisor and the two halves of an
// 8-bit dividend. Loading the low half also starts a restoring division of
// eight MSB-first steps. The result is {quotient[3:0], remainder[3:0]}, or
// 8'hFF when the divisor is zero or the quotient does not fit in 4 bits.
//
// Ports
//   clk     in   1  rising-edge clock
//   rst     in   1  synchronous, active-high reset
//   io_in   in   8  command: [7:6] op, [5:4] reserved, [3:0] nibble operand
//                   op 00 idle, 01 load divisor, 10 load dividend high,
//                   11 load dividend low and start
//   io_out  out  8  registered result byte; holds between results
// -----------------------------------------------------------------------------
module nibble_divider (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] OP_IDLE  = 2'b00;
    localparam logic [1:0] OP_DIV   = 2'b01;
    localparam logic [1:0] OP_HIGH  = 2'b10;
    localparam logic [1:0] OP_START = 2'b11;

    state_t     state_q;
    logic [7:0] in_q;       // registered command byte
    logic [3:0] divisor_q;  // programmed divisor
    logic [3:0] div_hi_q;   // programmed dividend high nibble
    logic [3:0] div_lo_q;   // programmed dividend low nibble
    logic [3:0] wdiv_q;     // divisor snapshot used by the running division
    logic [4:0] rem_q;      // partial remainder
    logic [7:0] quo_q;      // dividend bits shift out the top, quotient bits in
    logic [2:0] cnt_q;      // step count, 0..7
    logic [7:0] out_q;

    // One restoring-division step, evaluated from the current working state.
    logic [4:0] rem_shift;
    logic       step_ge;
    logic [4:0] rem_d;
    logic [7:0] quo_d;
    logic [7:0] result_d;

    always_comb begin
        rem_shift = {rem_q[3:0], quo_q[7]};
        step_ge   = (rem_shift >= {1'b0, wdiv_q});
        rem_d     = step_ge ? (rem_shift - {1'b0, wdiv_q}) : rem_shift;
        quo_d     = {quo_q[6:0], step_ge};
        // A zero divisor or a quotient above 15 cannot be encoded in the
        // nibble result, so both report the out-of-range code 8'hFF.
        if ((wdiv_q == 4'd0) || (quo_d[7:4] != 4'd0)) begin
            result_d = 8'hFF;
        end else begin
            result_d = {quo_d[3:0], rem_d[3:0]};
        end
    end

    // NOTE: sequential state uses non-blocking (<=) assignments so every
    // register samples the pre-edge values of the others. All state here is
    // flops (no memory arrays), so every register is cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            in_q      <= 8'h00;
            divisor_q <= 4'h0;
            div_hi_q  <= 4'h0;
            div_lo_q  <= 4'h0;
            wdiv_q    <= 4'h0;
            rem_q     <= 5'h00;
            quo_q     <= 8'h00;
            cnt_q     <= 3'd0;
            out_q     <= 8'h00;
        end else begin
            in_q <= io_in;
            unique case (state_q)
                IDLE: begin
                    unique case (in_q[7:6])
                        OP_IDLE: ;
                        OP_DIV:  divisor_q <= in_q[3:0];
                        OP_HIGH: div_hi_q  <= in_q[3:0];
                        OP_START: begin
                            div_lo_q <= in_q[3:0];
                            // Snapshot operands; the low nibble comes straight
                            // from the command since div_lo_q updates this edge.
                            wdiv_q   <= divisor_q;
                            quo_q    <= {div_hi_q, in_q[3:0]};
                            rem_q    <= 5'h00;
                            cnt_q    <= 3'd0;
                            state_q  <= RUN;
                        end
                        default: ;
                    endcase
                end
                RUN: begin
                    // Commands are not decoded here, so loads are ignored.
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        out_q   <= result_d;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign io_out = out_q;

endmodule

// File: tb/tb_nibble_divider.sv
// -----------------------------------------------------------------------------
// tb_nibble_divider
//
// Directed bench for nibble_divider. Each start pushes its expected io_out
// value and the cycle it must appear onto a scoreboard queue. A monitor on
// the falling edge retires entries that have come due into a model of io_out
// and compares the DUT against that model every cycle, which covers latency,
// hold-between-results and reset behaviour.
// -----------------------------------------------------------------------------
module tb_nibble_divider;

    logic       clk;
    logic       rst;
    logic [7:0] io_in;
    logic [7:0] io_out;

    nibble_divider dut (
        .clk   (clk),
        .rst   (rst),
        .io_in (io_in),
        .io_out(io_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [7:0] val;
    } sb_entry_t;

    sb_entry_t  sb[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic       mon_en = 1'b0;
    logic [7:0] model_out = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Falling-edge monitor: retire due entries, then compare.
    always @(negedge clk) begin
        if (mon_en) begin
            sb_entry_t e;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                model_out = e.val;
            end
            checks++;
            assert (io_out === model_out) else begin
                errors++;
                $error("FAIL io_out cyc=%0d observed=%h expected=%h", cyc, io_out, model_out);
            end
        end
    end

    function automatic logic [7:0] model(input int d, input int n);
        if (d == 0 || (n / d) > 15) return 8'hFF;
        return {4'(n / d), 4'(n % d)};
    endfunction

    task automatic drive(input logic [1:0] op, input logic [3:0] nib);
        @(negedge clk);
        rst   = 1'b0;
        io_in = {op, 2'b10, nib};  // reserved bits set to prove they are ignored
    endtask

    task automatic push(input int offset, input logic [7:0] val);
        sb.push_back('{cyc + offset, val});
    endtask

    task automatic idle(input int n);
        repeat (n) drive(2'b00, 4'h0);
    endtask

    task automatic run_div(input logic [3:0] d, input logic [3:0] hi, input logic [3:0] lo);
        drive(2'b01, d);
        drive(2'b10, hi);
        drive(2'b11, lo);
        push(10, model(int'(d), int'({hi, lo})));
        idle(10);
    endtask

    initial begin
        rst   = 1'b1;
        io_in = 8'h00;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;  // reset value 00 checked from here on

        // First command accepted in the cycle reset is released.
        run_div(4'hB, 4'h8, 4'hF);          // 143/11 -> D0

        run_div(4'h5, 4'h2, 4'hF);          // 47/5 -> 92
        drive(2'b11, 4'hE);                 // repeat start, 46/5 -> 91
        push(10, model(5, 8'h2E));
        idle(10);

        run_div(4'h0, 4'h2, 4'hA);          // divide by zero -> FF
        run_div(4'h3, 4'hC, 4'h8);          // quotient 66 -> FF

        // a*b / b == {a, 0}
        for (int i = 0; i < 4; i++) begin
            int a, b;
            a = 1 + (i * 4 + 3) % 15;
            b = 15 - i * 3;
            run_div(4'(b), 4'((a * b) >> 4), 4'(a * b));
        end
        run_div(4'hF, 4'hF, 4'hF);          // 255/15 = 17 -> FF
        run_div(4'h1, 4'h0, 4'hF);          // 15/1 -> F0

        // Busy ignore: divisor load at T+3 must not take effect.
        drive(2'b01, 4'h7);
        drive(2'b10, 4'h2);
        drive(2'b11, 4'hA);
        push(10, model(7, 8'h2A));
        idle(2);
        drive(2'b01, 4'h2);
        drive(2'b10, 4'hF);
        idle(6);
        drive(2'b11, 4'hA);                 // divisor and high nibble still 7, 2
        push(10, model(7, 8'h2A));
        idle(10);

        // A result other than 60 first, so the reset check sees a change.
        drive(2'b11, 4'hB);                 // 43/7 -> 61
        push(10, model(7, 8'h2B));
        idle(10);

        // Reset mid-run: start at T, reset at T+5, no late result.
        drive(2'b11, 4'hA);
        idle(4);
        @(negedge clk);
        rst   = 1'b1;
        io_in = 8'h00;
        push(1, 8'h00);
        idle(12);

        // Held start, restarting every 9 cycles; low nibble steps A, B, C.
        drive(2'b01, 4'h7);
        drive(2'b10, 4'h2);
        for (int k = 0; k < 27; k++) begin
            logic [3:0] lo;
            lo = 4'hA + 4'(k / 9);
            drive(2'b11, lo);
            if (k % 9 == 0) push(10, model(7, int'({4'h2, lo})));
        end
        idle(12);

        mon_en = 1'b0;
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d pending expected=0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
